dcache_ctrl: RTL and testbench

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_pkg.sv | 22 ++
 rtl/dcache_array.sv | 64 ++++++
 rtl/dcache_ctrl.sv | 136 +++++++++++++
 tb/tb_dcache_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int ADDR_W  = 32;
  localparam int WORD_W  = 32;
  localparam int LINE_W  = 128;
  localparam int OFF_LSB = 2;   // word offset starts above the byte bits
  localparam int OFF_W   = 2;   // four words per line
  localparam int IDX_LSB = 4;   // index starts above the 16-byte line offset

  typedef enum logic [1:0] {
    ST_COMPARE   = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2
  } state_t;

  // Tag width left over once offset and index bits are removed from the address.
  function automatic int tag_width(input int num_lines);
    return ADDR_W - IDX_LSB - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: asynchronous read, one word-write port, one line-write port.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 4,
  localparam int IDX_W = $clog2(NUM_LINES),
  localparam int TAG_W = tag_width(NUM_LINES)
) (
  input  logic              clk,
  input  logic              reset,
  // read port
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  // word write (store hit), marks the line dirty
  input  logic              ww_en,
  input  logic [IDX_W-1:0]  ww_idx,
  input  logic [OFF_W-1:0]  ww_off,
  input  logic [WORD_W-1:0] ww_data,
  // line write (refill), marks the line valid and clean
  input  logic              lw_en,
  input  logic [IDX_W-1:0]  lw_idx,
  input  logic [TAG_W-1:0]  lw_tag,
  input  logic [LINE_W-1:0] lw_data
);

  logic [LINE_W-1:0]    data_q [NUM_LINES];
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

  // Line status bits: cleared by reset, set by refill, dirtied by store hits.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (lw_en) begin
        valid_q[lw_idx] <= 1'b1;
        dirty_q[lw_idx] <= 1'b0;
      end
      if (ww_en) dirty_q[ww_idx] <= 1'b1;
    end
  end

  // Tag and data payload writes.
  // NOTE: no reset on tag/data arrays; valid bits gate their use, and leaving them unreset lets them map to RAM.
  always_ff @(posedge clk) begin
    if (lw_en) begin
      data_q[lw_idx] <= lw_data;
      tag_q[lw_idx]  <= lw_tag;
    end
    if (ww_en) data_q[ww_idx][ww_off*WORD_W +: WORD_W] <= ww_data;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller: FSM, memory interface, counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES      = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [127:0]  mem_wdata,
  input  logic [127:0]  mem_rdata,
  input  logic          mem_ready,
  output logic [15:0]   hit_cnt,
  output logic [15:0]   miss_cnt
);

  localparam int IDX_W    = $clog2(NUM_LINES);
  localparam int TAG_W    = tag_width(NUM_LINES);
  localparam int OFF_BITS = $clog2(WORDS_PER_LINE);

  // Address fields of the current CPU request.
  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [OFF_BITS-1:0] req_off;
  logic [1:0]          unused_byte_bits;

  assign req_tag          = cpu_addr[ADDR_W-1 -: TAG_W];
  assign req_idx          = cpu_addr[IDX_LSB +: IDX_W];
  assign req_off          = cpu_addr[OFF_LSB +: OFF_BITS];
  assign unused_byte_bits = cpu_addr[1:0];

  state_t           state;
  logic [TAG_W-1:0] lat_tag;
  logic [IDX_W-1:0] lat_idx;
  logic             after_refill;  // first COMPARE cycle after a refill: completion, not a new hit

  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;
  logic              access, hit, ww_en, lw_en;

  assign access = (state == ST_COMPARE) && cpu_req;
  assign hit    = rd_valid && (rd_tag == req_tag);
  assign ww_en  = access && hit && cpu_we;
  assign lw_en  = (state == ST_REFILL) && mem_req && mem_ready;

  // Stall and load data are gated by reset so an idle, reset cache presents nothing.
  assign cpu_stall = reset && ((state != ST_COMPARE) || (cpu_req && !hit));
  assign cpu_rdata = (reset && access && hit && !cpu_we) ?
                     rd_line[req_off*WORD_W +: WORD_W] : '0;

  dcache_array #(.NUM_LINES(NUM_LINES)) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .ww_en    (ww_en),
    .ww_idx   (req_idx),
    .ww_off   (req_off),
    .ww_data  (cpu_wdata),
    .lw_en    (lw_en),
    .lw_idx   (lat_idx),
    .lw_tag   (lat_tag),
    .lw_data  (mem_rdata)
  );

  // Miss-handling FSM with registered memory-side outputs and performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_COMPARE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      lat_tag      <= '0;
      lat_idx      <= '0;
      after_refill <= 1'b0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
    end else begin
      case (state)
        ST_COMPARE: begin
          after_refill <= 1'b0;
          if (cpu_req) begin
            if (hit) begin
              if (!after_refill) hit_cnt <= hit_cnt + 16'd1;
            end else begin
              miss_cnt  <= miss_cnt + 16'd1;
              lat_tag   <= req_tag;
              lat_idx   <= req_idx;
              mem_req   <= 1'b1;
              mem_wdata <= rd_line;
              if (rd_valid && rd_dirty) begin
                state    <= ST_WRITEBACK;
                mem_we   <= 1'b1;
                mem_addr <= {rd_tag, req_idx, {IDX_LSB{1'b0}}};
              end else begin
                state    <= ST_REFILL;
                mem_we   <= 1'b0;
                mem_addr <= {req_tag, req_idx, {IDX_LSB{1'b0}}};
              end
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_ready) begin
            state    <= ST_REFILL;
            mem_we   <= 1'b0;
            mem_addr <= {lat_tag, lat_idx, {IDX_LSB{1'b0}}};
          end
        end
        ST_REFILL: begin
          if (mem_ready) begin
            state        <= ST_COMPARE;
            mem_req      <= 1'b0;
            after_refill <= 1'b1;
          end
        end
        default: state <= ST_COMPARE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl with a 3-cycle-latency line memory model.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_stall;
  logic         mem_req, mem_we, mem_ready;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic [15:0]  hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;

  dcache_ctrl #(.NUM_LINES(4), .WORDS_PER_LINE(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- memory model: word at address a reads a unless written ----------------
  logic [31:0] mem_w [logic [31:0]];
  int          mcnt = 0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return mem_w.exists(a) ? mem_w[a] : a;
  endfunction

  assign mem_ready = mem_req && (mcnt == 2);

  // Refill data presented from the model for the current line address.
  always @(negedge clk)
    mem_rdata <= {rd_word(mem_addr + 32'd12), rd_word(mem_addr + 32'd8),
                  rd_word(mem_addr + 32'd4),  rd_word(mem_addr)};

  // Transaction timing and writeback capture.
  always @(posedge clk) begin
    if (mem_req && mem_ready && mem_we)
      for (int i = 0; i < 4; i++) mem_w[mem_addr + 32'(4*i)] = mem_wdata[32*i +: 32];
    if (!mem_req || mem_ready) mcnt <= 0;
    else                       mcnt <= mcnt + 1;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int          stalls;
  logic        done, wb_seen, rf_seen;
  logic [31:0] rdata_seen, wb_addr, wb_word1, rf_addr;

  // One CPU access held until cpu_stall drops; records memory transactions on the way.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    stalls = 0; done = 1'b0; wb_seen = 1'b0; rf_seen = 1'b0;
    rdata_seen = '0; wb_addr = '0; wb_word1 = '0; rf_addr = '0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (mem_req && mem_ready) begin
        if (mem_we) begin wb_seen = 1'b1; wb_addr = mem_addr; wb_word1 = mem_wdata[63:32]; end
        else        begin rf_seen = 1'b1; rf_addr = mem_addr; end
      end
      if (!cpu_stall) begin done = 1'b1; rdata_seen = cpu_rdata; end
      else stalls++;
    end
    check($sformatf("access_done_%0h", addr), done, 1'b1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_stalls;
    logic        exp_wb;
    logic [31:0] exp_wb_addr;
    logic [31:0] exp_wb_word1;
    logic [31:0] exp_rf_addr;
    logic [15:0] exp_hits;
    logic [15:0] exp_misses;
  } vec_t;

  vec_t vecs [9];
  logic reached;

  initial begin
    // we, addr, wdata, rdata, stalls, wb, wb_addr, wb_word1, rf_addr, hits, misses
    vecs[0] = '{1'b0, 32'h40, 32'h0,        32'h40,       4, 1'b0, 32'h0,  32'h0,        32'h40, 16'd0, 16'd1};
    vecs[1] = '{1'b0, 32'h44, 32'h0,        32'h44,       0, 1'b0, 32'h0,  32'h0,        32'h0,  16'd1, 16'd1};
    vecs[2] = '{1'b1, 32'h44, 32'hDEADBEEF, 32'h0,        0, 1'b0, 32'h0,  32'h0,        32'h0,  16'd2, 16'd1};
    vecs[3] = '{1'b0, 32'h84, 32'h0,        32'h84,       7, 1'b1, 32'h40, 32'hDEADBEEF, 32'h80, 16'd2, 16'd2};
    vecs[4] = '{1'b1, 32'h14, 32'h12345678, 32'h0,        4, 1'b0, 32'h0,  32'h0,        32'h10, 16'd2, 16'd3};
    vecs[5] = '{1'b0, 32'h14, 32'h0,        32'h12345678, 0, 1'b0, 32'h0,  32'h0,        32'h0,  16'd3, 16'd3};
    vecs[6] = '{1'b0, 32'h54, 32'h0,        32'h54,       7, 1'b1, 32'h10, 32'h12345678, 32'h50, 16'd3, 16'd4};
    vecs[7] = '{1'b0, 32'h44, 32'h0,        32'hDEADBEEF, 4, 1'b0, 32'h0,  32'h0,        32'h40, 16'd3, 16'd5};
    vecs[8] = '{1'b0, 32'h14, 32'h0,        32'h12345678, 4, 1'b0, 32'h0,  32'h0,        32'h10, 16'd3, 16'd6};

    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_stall",   cpu_stall, 1'b0);
    check("rst_mem_req", mem_req,   1'b0);
    check("rst_mem_we",  mem_we,    1'b0);
    check("rst_rdata",   cpu_rdata, 32'h0);
    check("rst_hits",    hit_cnt,   16'd0);
    check("rst_misses",  miss_cnt,  16'd0);
    cpu_req = 1'b1; cpu_addr = 32'h40; #1;
    check("rst_stall_with_req", cpu_stall, 1'b0);
    cpu_req = 1'b0;
    @(negedge clk); reset = 1'b1;

    // Idle cycles in COMPARE change nothing.
    repeat (3) @(negedge clk);
    check("idle_stall",   cpu_stall, 1'b0);
    check("idle_mem_req", mem_req,   1'b0);
    check("idle_hits",    hit_cnt,   16'd0);
    check("idle_misses",  miss_cnt,  16'd0);

    // Table-driven access sequence.
    for (int i = 0; i < 9; i++) begin
      run_access(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check($sformatf("v%0d_stalls", i), stalls, vecs[i].exp_stalls);
      if (!vecs[i].we) check($sformatf("v%0d_rdata", i), rdata_seen, vecs[i].exp_rdata);
      check($sformatf("v%0d_wb_seen", i), wb_seen, vecs[i].exp_wb);
      if (vecs[i].exp_wb) begin
        check($sformatf("v%0d_wb_addr", i),  wb_addr,  vecs[i].exp_wb_addr);
        check($sformatf("v%0d_wb_word1", i), wb_word1, vecs[i].exp_wb_word1);
      end
      check($sformatf("v%0d_rf_seen", i), rf_seen, vecs[i].exp_stalls != 0);
      if (vecs[i].exp_stalls != 0) check($sformatf("v%0d_rf_addr", i), rf_addr, vecs[i].exp_rf_addr);
      check($sformatf("v%0d_hits", i),   hit_cnt,  vecs[i].exp_hits);
      check($sformatf("v%0d_misses", i), miss_cnt, vecs[i].exp_misses);
    end

    // Miss keeps going after cpu_req drops; stall stays high during refill.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hC0;
    @(negedge clk);
    check("drop_miss_stall", cpu_stall, 1'b1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    check("drop_refill_stall", cpu_stall, 1'b1);
    check("drop_refill_req",   mem_req,   1'b1);
    reached = 1'b0;
    for (int c = 0; c < 20 && !reached; c++) begin
      @(negedge clk);
      if (!mem_req) reached = 1'b1;
    end
    check("drop_refill_done", reached, 1'b1);
    check("drop_misses", miss_cnt, 16'd7);
    check("drop_hits",   hit_cnt,  16'd3);
    run_access(1'b0, 32'hC0, 32'h0);
    check("drop_after_stalls", stalls, 0);
    check("drop_after_rdata",  rdata_seen, 32'hC0);
    check("drop_after_hits",   hit_cnt, 16'd4);

    // Hit counter wraps 0xFFFF -> 0 under back-to-back hits.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hC0;
    reached = 1'b0;
    for (int c = 0; c < 70000 && !reached; c++) begin
      @(negedge clk);
      if (hit_cnt == 16'hFFFF) reached = 1'b1;
    end
    check("wrap_reach", hit_cnt, 16'hFFFF);
    @(negedge clk);
    check("wrap_zero",   hit_cnt,  16'h0000);
    check("wrap_misses", miss_cnt, 16'd7);
    check("wrap_rdata",  cpu_rdata, 32'hC0);
    @(posedge clk); #1;
    cpu_req = 1'b0;

    // Reset during REFILL abandons the transaction.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
    reached = 1'b0;
    for (int c = 0; c < 10 && !reached; c++) begin
      @(negedge clk);
      if (mem_req && !mem_we) reached = 1'b1;
    end
    check("mid_reached_refill", reached, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_mem_req", mem_req,   1'b0);
    check("mid_rst_mem_we",  mem_we,    1'b0);
    check("mid_rst_stall",   cpu_stall, 1'b0);
    check("mid_rst_rdata",   cpu_rdata, 32'h0);
    check("mid_rst_hits",    hit_cnt,   16'd0);
    check("mid_rst_misses",  miss_cnt,  16'd0);
    cpu_req = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    run_access(1'b0, 32'h40, 32'h0);
    check("post_rst_stalls",  stalls, 4);
    check("post_rst_rf_addr", rf_addr, 32'h40);
    check("post_rst_wb_seen", wb_seen, 1'b0);
    check("post_rst_rdata",   rdata_seen, 32'h40);
    check("post_rst_misses",  miss_cnt, 16'd1);
    check("post_rst_hits",    hit_cnt,  16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
